led_matrix_scan_driver: RTL and testbench

- Downstream consumer of the 8x8 RGB bitmap generator. Takes the 8-row x 24-bit frame (per row: three 8-bit colour planes) and drives an external shift-register LED matrix: serial data, shift clock, latch, one-hot row enable and output-enable blanking.
- Holds an internal shadow frame so that generator changes never tear a displayed frame.
- Issues a one-cycle frame_sync pulse per frame, intended to drive the generator's clk_en.

---
 rtl/led_matrix_scan_driver.sv | 215 +++++++++++++++++++++
 tb/tb_led_matrix_scan_driver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan_driver.sv
// Row-scanned shift-register LED matrix driver fed from an 8x24 bitmap, with a shadow frame captured once per frame.
// Optional macro LED_MATRIX_BRIGHTNESS_PWM_EN adds a 3-bit brightness input that shortens the lit window in RUN.
module led_matrix_scan_driver #(
  parameter int CLK_DIV    = 4,
  parameter int ROW_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  input  logic [2:0]       brightness,
`endif
  input  logic [7:0][23:0] frame_in,
  output logic             frame_sync,
  output logic             sr_data,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             oe_n,
  output logic [7:0]       row_en
);

  localparam int CW = $clog2(ROW_PERIOD + 1);
  localparam int PW = $clog2(2 * CLK_DIV + 1);

  localparam logic [CW-1:0] C_ZERO      = CW'(0);
  localparam logic [CW-1:0] C_LAST      = CW'(ROW_PERIOD - 1);
  localparam logic [CW-1:0] C_SHIFT_END = CW'(48 * CLK_DIV);
  localparam logic [CW-1:0] C_LATCH     = CW'(ROW_PERIOD - CLK_DIV);
  localparam logic [CW-1:0] C_BLANK     = CW'(ROW_PERIOD - CLK_DIV - 1);
  localparam logic [PW-1:0] P_ZERO      = PW'(0);
  localparam logic [PW-1:0] P_LAST      = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] P_HIGH      = PW'(CLK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_phase;
  logic [4:0]        r_bit;
  logic [2:0]        r_ptr;
  logic              r_stop;
  logic [7:0][23:0]  r_shadow;
  logic              r_frame_sync;
  logic              r_sr_data;
  logic              r_sr_clk;
  logic              r_sr_latch;
  logic              r_oe_n;
  logic [7:0]        r_row_en;

  state_t            w_state_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [PW-1:0]     w_phase_nxt;
  logic [4:0]        w_bit_nxt;
  logic [2:0]        w_ptr_nxt;
  logic              w_stop_nxt;

  // Next-state, slot counter and bit/phase tracking for the serial shifter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_ptr_nxt   = r_ptr;
    w_stop_nxt  = r_stop;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt   = C_ZERO;
        w_phase_nxt = P_ZERO;
        w_bit_nxt   = 5'd23;
        w_ptr_nxt   = 3'd7;
        w_stop_nxt  = 1'b0;
        if (enable) begin
          w_state_nxt = ST_PRIME;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRIME, ST_RUN: begin
        if (!enable) begin
          w_stop_nxt = 1'b1;
        end else begin
          w_stop_nxt = r_stop;
        end
        if (r_cnt == C_LAST) begin
          w_cnt_nxt   = C_ZERO;
          w_phase_nxt = P_ZERO;
          w_bit_nxt   = 5'd23;
          // A stop request latched anywhere in the slot takes effect only here, after the latch window
          if (r_stop || !enable) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = 3'd7;
            w_stop_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_RUN;
            w_ptr_nxt   = r_ptr + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_phase == P_LAST) begin
            w_phase_nxt = P_ZERO;
            if (r_bit != 5'd0) begin
              w_bit_nxt = r_bit - 5'd1;
            end else begin
              w_bit_nxt = r_bit;
            end
          end else begin
            w_phase_nxt = r_phase + PW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = C_ZERO;
        w_phase_nxt = P_ZERO;
        w_bit_nxt   = 5'd23;
        w_ptr_nxt   = 3'd7;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  logic        w_active;
  logic [2:0]  w_shift_row;
  logic        w_capture;
  logic [23:0] w_src_row;
  logic        w_in_shift;
  logic        w_pwm_ok;

  assign w_active    = (w_state_nxt != ST_IDLE);
  assign w_shift_row = w_ptr_nxt + 3'd1;
  assign w_capture   = w_active && (w_cnt_nxt == C_ZERO) && (w_shift_row == 3'd0);
  // On the capture cycle the shadow is being loaded, so row 0 comes straight from frame_in
  assign w_src_row   = w_capture ? frame_in[0] : r_shadow[w_shift_row];
  assign w_in_shift  = w_active && (w_cnt_nxt < C_SHIFT_END);

`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  localparam logic [CW+3:0] C_ON_LEN = (CW + 4)'(ROW_PERIOD - CLK_DIV - 1);
  logic [2:0]    r_bright;
  logic [2:0]    w_bright;
  logic [CW+3:0] w_on_prod;
  logic [CW+3:0] w_on_len;

  assign w_bright  = (w_cnt_nxt == C_ZERO) ? brightness : r_bright;
  assign w_on_prod = ((CW + 4)'(w_bright) + (CW + 4)'(1)) * C_ON_LEN;
  assign w_on_len  = w_on_prod >> 3;
  assign w_pwm_ok  = ({4'b0000, w_cnt_nxt} < w_on_len);

  // Brightness held for the whole slot once sampled at its start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bright <= 3'd7;
    end else begin
      r_bright <= w_bright;
    end
  end
`else
  assign w_pwm_ok = 1'b1;
`endif

  // Control state, counters and shadow frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= C_ZERO;
      r_phase  <= P_ZERO;
      r_bit    <= 5'd23;
      r_ptr    <= 3'd7;
      r_stop   <= 1'b0;
      r_shadow <= {8{24'h000000}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
      r_ptr   <= w_ptr_nxt;
      r_stop  <= w_stop_nxt;
      if (w_capture) begin
        r_shadow <= frame_in;
      end else begin
        r_shadow <= r_shadow;
      end
    end
  end

  // Output registers computed from next-state so they line up with the counter value they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_sync <= 1'b0;
      r_sr_data    <= 1'b0;
      r_sr_clk     <= 1'b0;
      r_sr_latch   <= 1'b0;
      r_oe_n       <= 1'b1;
      r_row_en     <= 8'h00;
    end else begin
      r_frame_sync <= w_capture;
      r_sr_data    <= w_in_shift ? w_src_row[w_bit_nxt] : 1'b0;
      r_sr_clk     <= w_in_shift && (w_phase_nxt >= P_HIGH);
      r_sr_latch   <= w_active && (w_cnt_nxt >= C_LATCH);
      r_oe_n       <= !((w_state_nxt == ST_RUN) && (w_cnt_nxt < C_BLANK) && w_pwm_ok);
      r_row_en     <= (w_state_nxt == ST_RUN) ? (8'd1 << w_ptr_nxt) : 8'h00;
    end
  end

  assign frame_sync = r_frame_sync;
  assign sr_data    = r_sr_data;
  assign sr_clk     = r_sr_clk;
  assign sr_latch   = r_sr_latch;
  assign oe_n       = r_oe_n;
  assign row_en     = r_row_en;

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Directed bench for led_matrix_scan_driver (CLK_DIV=1, ROW_PERIOD=64); decodes one row slot at a time.
module tb_led_matrix_scan_driver;
  localparam int CD = 1;
  localparam int RP = 64;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic [7:0][23:0] frame_in;
  logic             frame_sync, sr_data, sr_clk, sr_latch, oe_n;
  logic [7:0]       row_en;
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
  logic [2:0]       brightness = 3'd7;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_sync = 0;
  int sync_gap = 0;

  led_matrix_scan_driver #(.CLK_DIV(CD), .ROW_PERIOD(RP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
    .brightness (brightness),
`endif
    .frame_in   (frame_in),
    .frame_sync (frame_sync),
    .sr_data    (sr_data),
    .sr_clk     (sr_clk),
    .sr_latch   (sr_latch),
    .oe_n       (oe_n),
    .row_en     (row_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observes one whole slot starting at its cnt=0 cycle; leaves the bench at the next slot's cnt=0
  task automatic check_slot(input string tag, input logic [23:0] exp_bits, input logic [7:0] exp_row,
                            input int exp_oe_low, input int exp_sync, input int drop_at, input int ren_at);
    logic [23:0] bits;
    logic [7:0]  row0;
    logic        prev;
    logic        latch_last;
    int nlatch, nsync, noe, nbad, sync_at;
    bits = 24'h0; prev = 1'b0; latch_last = 1'b0; row0 = row_en;
    nlatch = 0; nsync = 0; noe = 0; nbad = 0; sync_at = -1;
    for (int i = 0; i < RP; i++) begin
      if (sr_clk && !prev) bits = {bits[22:0], sr_data};
      prev = sr_clk;
      if (sr_latch) nlatch++;
      if (i == RP - 1) latch_last = sr_latch;
      if (frame_sync) begin
        nsync++;
        sync_at = i;
        sync_gap = cyc - last_sync;
        last_sync = cyc;
      end
      if (!oe_n) noe++;
      if ((sr_latch && sr_clk) || ($countones(row_en) > 1) || (row_en !== row0)) nbad++;
      if (i == drop_at) enable = 1'b0;
      if (i == ren_at) enable = 1'b1;
      tick();
    end
    chk({tag, "_bits"}, {8'h00, bits}, {8'h00, exp_bits});
    chk({tag, "_row_en"}, {24'h0, row0}, {24'h0, exp_row});
    chk({tag, "_oe_low"}, noe, exp_oe_low);
    chk({tag, "_sync_cnt"}, nsync, exp_sync);
    if (exp_sync == 1) chk({tag, "_sync_at"}, sync_at, 0);
    chk({tag, "_latch_cnt"}, nlatch, 1);
    chk({tag, "_latch_last"}, {31'h0, latch_last}, 32'h1);
    chk({tag, "_invariant"}, nbad, 0);
  endtask

  initial begin
    frame_in[0] = 24'h003C00;
    for (int r = 1; r < 8; r++) frame_in[r] = 24'hA00000 + 24'(r);

    // Reset values
    repeat (3) tick();
    chk("rst_sr_data", {31'h0, sr_data}, 32'h0);
    chk("rst_sr_clk", {31'h0, sr_clk}, 32'h0);
    chk("rst_sr_latch", {31'h0, sr_latch}, 32'h0);
    chk("rst_oe_n", {31'h0, oe_n}, 32'h1);
    chk("rst_row_en", {24'h0, row_en}, 32'h0);
    chk("rst_frame_sync", {31'h0, frame_sync}, 32'h0);

    rst_n = 1'b1;
    tick();
    chk("idle_oe_n", {31'h0, oe_n}, 32'h1);
    chk("idle_sync", {31'h0, frame_sync}, 32'h0);

    // Prime slot shifts row 0
    enable = 1'b1;
    tick();
    check_slot("prime", 24'h003C00, 8'h00, 0, 1, -1, -1);
    chk("prime_row_en", {24'h0, row_en}, 32'h01);
    chk("prime_oe_n", {31'h0, oe_n}, 32'h0);
    chk("prime_latch_off", {31'h0, sr_latch}, 32'h0);

    // Full scan; frame_in changes after row 3 has been shifted
    for (int k = 0; k < 8; k++) begin
      logic [23:0] eb;
      if (k == 3) begin
        frame_in[0] = 24'h5A5A5A;
        for (int r = 1; r < 8; r++) frame_in[r] = 24'hB00000 + 24'(r);
      end
      eb = (k == 7) ? 24'h5A5A5A : (24'hA00000 + 24'(k + 1));
      check_slot($sformatf("scan%0d", k), eb, 8'(1 << k), 62, (k == 7) ? 1 : 0, -1, -1);
    end
    chk("sync_period", sync_gap, 8 * RP);

    for (int k = 0; k < 5; k++) begin
      check_slot($sformatf("new%0d", k), 24'hB00000 + 24'(k + 1), 8'(1 << k), 62, 0, -1, -1);
    end

    // Stop request during the row 5 slot, re-asserted before the slot ends
    check_slot("stop", 24'hB00006, 8'h20, 62, 0, 10, 40);
    chk("stop_oe_n", {31'h0, oe_n}, 32'h1);
    chk("stop_row_en", {24'h0, row_en}, 32'h0);
    chk("stop_sync", {31'h0, frame_sync}, 32'h0);
    chk("stop_latch", {31'h0, sr_latch}, 32'h0);
    tick();
    check_slot("reprime", 24'h5A5A5A, 8'h00, 0, 1, -1, -1);
    chk("reprime_row_en", {24'h0, row_en}, 32'h01);

    // Asynchronous reset in the middle of the shift window
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_sr_clk", {31'h0, sr_clk}, 32'h0);
    chk("arst_sr_latch", {31'h0, sr_latch}, 32'h0);
    chk("arst_oe_n", {31'h0, oe_n}, 32'h1);
    chk("arst_row_en", {24'h0, row_en}, 32'h0);
    repeat (2) tick();
    chk("arst_hold_latch", {31'h0, sr_latch}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_slot("arst_prime", 24'h5A5A5A, 8'h00, 0, 1, -1, -1);
    chk("arst_row_en_after", {24'h0, row_en}, 32'h01);

`ifdef LED_MATRIX_BRIGHTNESS_PWM_EN
    brightness = 3'd3;
    check_slot("pwm7", 24'hB00001, 8'h01, 62, 0, -1, -1);
    check_slot("pwm3", 24'hB00002, 8'h02, 31, 0, -1, -1);
`else
    check_slot("run", 24'hB00001, 8'h01, 62, 0, -1, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
